// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and the
// per-operation context latched when a request is accepted.
package mdu_pkg;
  localparam int MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } mdu_state_e;

  typedef struct packed {
    logic is_div;
    logic neg_q;   // negate product / quotient
    logic neg_r;   // negate remainder (dividend was negative)
    logic div0;
  } mdu_ctx_t;
endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring-divide trial subtract
// on the shared 2*WIDTH accumulator.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_is_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opd,
  output logic [2*WIDTH-1:0] o_acc
);
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem;

  // Multiply: acc = {partial, multiplier}; carry kept in the extra sum bit.
  assign w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opd} : '0);

  // Divide: acc = {remainder, dividend/quotient}; shifted remainder is WIDTH+1 bits.
  assign w_trial = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
  assign w_qbit  = (w_trial >= {1'b0, i_opd});
  assign w_rem   = w_qbit ? WIDTH'(w_trial - {1'b0, i_opd}) : w_trial[WIDTH-1:0];

  assign o_acc = i_is_div ? {w_rem, i_acc[WIDTH-2:0], w_qbit}
                          : {w_sum, i_acc[WIDTH-1:1]};
endmodule

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; works on magnitudes for
// WIDTH cycles, then applies sign correction in a single FIX cycle.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  mdu_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opd;
  logic [WIDTH-1:0]   r_a;
  mdu_ctx_t           r_ctx;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_busy, r_done;

  mdu_op_e            w_op;
  logic               w_is_div, w_signed;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;

  assign w_op     = mdu_op_e'(op);
  assign w_is_div = (w_op == MDU_DIV) || (w_op == MDU_DIVU);
  assign w_signed = (w_op == MDU_MULT) || (w_op == MDU_DIV);
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div (r_ctx.is_div),
    .i_acc    (r_acc),
    .i_opd    (r_opd),
    .o_acc    (w_step)
  );

  // 0x80000000 / -1 needs no special case: magnitude 2^31 negates to itself.
  assign w_prod = r_ctx.neg_q ? -r_acc : r_acc;
  assign w_quo  = r_ctx.neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_ctx.neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opd   <= '0;
      r_a     <= '0;
      r_ctx   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (w_op)
              MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                r_acc   <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                r_opd   <= w_is_div ? w_b_mag : w_a_mag;
                r_a     <= a;
                r_ctx   <= '{is_div: w_is_div, neg_q: w_a_neg ^ w_b_neg,
                             neg_r: w_a_neg, div0: (b == '0)};
                r_cnt   <= '0;
                r_busy  <= 1'b1;
                r_state <= S_CALC;
              end
              MDU_MTHI: r_hi <= a;
              MDU_MTLO: r_lo <= a;
              default: ;
            endcase
          end
        end
        S_CALC: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          if (!r_ctx.is_div) begin
            {r_hi, r_lo} <= w_prod;
          end else if (r_ctx.div0) begin
            r_hi <= r_a;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;
endmodule

// File: tb/tb_mdu.sv
// Directed plus random bench for mdu; expected HI/LO come from 64-bit
// integer arithmetic, latency and busy width from the cycle rules.
module tb_mdu;
  import mdu_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int nchk = 0;
  int nerr = 0;

  mdu #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_model(input int o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                                    output logic [W-1:0] eh, output logic [W-1:0] el);
    longint sa, sb;
    logic [2*W-1:0] p;
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    eh = '0;
    el = '0;
    case (o)
      0: begin p = 64'(sa * sb); {eh, el} = p; end
      1: begin p = 64'(ia) * 64'(ib); {eh, el} = p; end
      2, 3: begin
        if (ib == '0) begin
          el = '1;
          eh = ia;
        end else if (o == 2) begin
          el = 32'(sa / sb);
          eh = 32'(sa % sb);
        end else begin
          el = ia / ib;
          eh = ia % ib;
        end
      end
      default: ;
    endcase
  endfunction

  // Called at #1 after a posedge; returns at #1 after the edge where done is seen.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input bit poke);
    logic [W-1:0] eh, el, h0, l0;
    int  lat, bcnt;
    bit  held, bdone;
    ref_model(int'(o), ia, ib, eh, el);
    h0 = hi; l0 = lo; held = 1'b1; bcnt = 0; lat = 0; bdone = 1'b1;
    start = 1'b1; op = o; a = ia; b = ib;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy) bcnt++;
    for (int k = 1; k <= 100; k++) begin
      if (poke && k == 5) begin
        start = 1'b1; op = MDU_MULT; a = $urandom; b = $urandom;
      end
      if (poke && k == 6) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        lat   = k;
        bdone = busy;
        break;
      end
      if (busy) bcnt++;
      if (hi !== h0 || lo !== l0) held = 1'b0;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(LAT));
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(LAT));
    chk({tag, "_busy_at_done"}, 32'(bdone), 32'(0));
    chk({tag, "_hilo_held"}, 32'(held), 32'(1));
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
  endtask

  initial begin
    logic [W-1:0] ra, rb, h_prev, l_prev;
    logic [2:0]   rop;
    rst = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    #2;
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu_max_hi_abs", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo_abs", lo, 32'h0000_0001);
    run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
    chk("mult_neg_lo_abs", lo, 32'hFFFF_FFF1);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_neg_lo_abs", lo, 32'hFFFF_FFFD);
    run_op("divu", 3'd3, 32'd100, 32'd7, 1'b0);
    chk("divu_lo_abs", lo, 32'd14);
    run_op("divu_zero", 3'd3, 32'd5, 32'd0, 1'b0);
    run_op("div_zero_neg", 3'd2, 32'hFFFF_FF00, 32'd0, 1'b0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_ovf_lo_abs", lo, 32'h8000_0000);
    run_op("mult_poked", 3'd0, 32'h0001_2345, 32'hFFFF_FF80, 1'b1);

    for (int i = 0; i < 12; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if (i % 3 == 1) ra = {1'b1, ra[W-2:0]};
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 1'b0);
    end

    start = 1'b1; op = MDU_MTHI; a = 32'h1234_5678;
    @(posedge clk); #1; start = 1'b0;
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", 32'(busy), 32'(0));
    chk("mthi_done", 32'(done), 32'(0));
    start = 1'b1; op = MDU_MTLO; a = 32'hCAFE_BABE;
    @(posedge clk); #1; start = 1'b0;
    chk("mtlo_lo", lo, 32'hCAFE_BABE);
    chk("mtlo_hi_kept", hi, 32'h1234_5678);
    chk("mtlo_busy", 32'(busy), 32'(0));
    @(posedge clk); #1;
    chk("mtlo_done", 32'(done), 32'(0));

    h_prev = hi; l_prev = lo;
    start = 1'b1; op = 3'd6; a = $urandom; b = $urandom;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    chk("nop_hi", hi, h_prev);
    chk("nop_lo", lo, l_prev);
    chk("nop_busy", 32'(busy), 32'(0));
    chk("nop_done", 32'(done), 32'(0));

    start = 1'b1; op = MDU_MULT; a = $urandom; b = $urandom;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_hi", hi, '0);
    chk("midrst_lo", lo, '0);
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst_multu", 3'd1, 32'd3, 32'd4, 1'b0);
    chk("post_rst_lo_abs", lo, 32'd12);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
